dma_io_endpoint: RTL and testbench

- Peripheral-side responder of the single-channel DREQ/DACK DMA handshake, i.e. the I/O device a DMA channel services.
- Buffers device data in a small FIFO and raises DREQ when a transfer is possible.
- Answers DMA IOR_N strobes by driving the data bus from the FIFO (device-to-memory), or IOW_N strobes by capturing the data bus into the FIFO (memory-to-device).
- Tracks terminal count (EOP_N) and protocol errors.

---
 rtl/dma_endpoint_pkg.sv | 16 +
 rtl/dma_ep_fifo.sv | 61 ++++++
 rtl/dma_io_endpoint.sv | 213 +++++++++++++++++++++
 tb/tb_dma_io_endpoint.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_endpoint_pkg.sv
// Shared types for the DREQ/DACK DMA I/O endpoint.
//   ep_state_e  : endpoint handshake state (IDLE, REQ, XFER, DONE)
//   DIR_*       : transfer direction encodings for the dir input / latched dir
package dma_endpoint_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } ep_state_e;

  localparam logic DIR_DEV2MEM = 1'b0;
  localparam logic DIR_MEM2DEV = 1'b1;

endpackage

// File: rtl/dma_ep_fifo.sv
// Synchronous FIFO for the DMA endpoint.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   push, wdata         : write request/data (ignored when full)
//   pop                 : read request (ignored when empty)
//   rdata               : current head entry (combinational)
//   full, empty, count  : occupancy status
// Push while full is dropped even if a pop happens in the same cycle.
module dma_ep_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DATA_W-1:0]             wdata,
  input  logic                          pop,
  output logic [DATA_W-1:0]             rdata,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally (power-of-2 depth)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dma_io_endpoint.sv
// Peripheral-side responder of a single-channel DREQ/DACK DMA handshake.
// Buffers device data in a FIFO, raises DREQ when a transfer is possible and
// serves IOR_N (device-to-memory) or IOW_N (memory-to-device) strobes.
// Ports:
//   CLK, RESET                      : clock, synchronous active-high reset
//   dir, enable                     : direction (sampled in IDLE), service enable
//   DREQ, DACK, IOR_N, IOW_N, EOP_N : DMA handshake
//   DB_in, DB_out, DB_oe            : DMA data bus
//   devWr*, devRd*                  : local push (dir=0) / pop (dir=1) ports
//   fifoCount                       : FIFO occupancy
//   tcSeen, tcClear                 : sticky terminal-count flag and its clear
//   protoErr                        : sticky protocol error
// Build option: define DMA_DEMAND_MODE_EN to keep DREQ asserted across
// successive strobes (demand mode); default is single-transfer mode.
module dma_io_endpoint
  import dma_endpoint_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          dir,
  input  logic                          enable,
  output logic                          DREQ,
  input  logic                          DACK,
  input  logic                          IOR_N,
  input  logic                          IOW_N,
  input  logic                          EOP_N,
  input  logic [DATA_W-1:0]             DB_in,
  output logic [DATA_W-1:0]             DB_out,
  output logic                          DB_oe,
  input  logic [DATA_W-1:0]             devWrData,
  input  logic                          devWrValid,
  output logic                          devWrReady,
  output logic [DATA_W-1:0]             devRdData,
  output logic                          devRdValid,
  input  logic                          devRdReady,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
  output logic                          tcSeen,
  input  logic                          tcClear,
  output logic                          protoErr
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  ep_state_e         state_q, state_d;
  logic              dir_q, dir_d;
  logic              rd_act_q, rd_act_d;
  logic              wr_act_q, wr_act_d;
  logic              eop_q, eop_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              dreq_q;
  logic              tc_seen_q;
  logic              proto_err_q;

  logic              dma_pop_c;
  logic              dma_push_c;
  logic              err_set_c;
  logic              rd_strobe_c;
  logic              xfer_more_c;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_wdata;
  logic [DATA_W-1:0] fifo_head;
  logic [CNT_W-1:0]  fifo_count;

  // Single push/pop ports shared between local and DMA sides by latched dir
  assign fifo_push  = (dir_q == DIR_DEV2MEM) ? devWrValid : dma_push_c;
  assign fifo_pop   = (dir_q == DIR_DEV2MEM) ? dma_pop_c  : devRdReady;
  assign fifo_wdata = (dir_q == DIR_DEV2MEM) ? devWrData  : wdata_q;

  dma_ep_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Valid DMA read strobe: bus is driven for exactly the cycles IOR_N is low
  assign rd_strobe_c = (state_q == XFER) && (dir_q == DIR_DEV2MEM) && DACK && !IOR_N && IOW_N;

  // Whether XFER may continue after a completed strobe
`ifdef DMA_DEMAND_MODE_EN
  always_comb begin
    xfer_more_c = 1'b0;
    if (dir_q == DIR_DEV2MEM) xfer_more_c = DACK && (fifo_count > CNT_W'(1));
    else                      xfer_more_c = DACK && (fifo_count < CNT_W'(FIFO_DEPTH - 1));
  end
`else
  assign xfer_more_c = 1'b0;
`endif

  // Handshake FSM: next state, strobe tracking and FIFO requests
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    rd_act_d   = 1'b0;
    wr_act_d   = 1'b0;
    eop_d      = 1'b0;
    wdata_d    = wdata_q;
    dma_pop_c  = 1'b0;
    dma_push_c = 1'b0;
    err_set_c  = 1'b0;

    case (state_q)
      IDLE: begin
        dir_d = dir;
        if (enable && (((dir == DIR_DEV2MEM) && !fifo_empty) ||
                       ((dir == DIR_MEM2DEV) && !fifo_full)))
          state_d = REQ;
      end

      REQ: begin
        if (DACK)         state_d = XFER;
        else if (!enable) state_d = IDLE;
      end

      XFER: begin
        rd_act_d = rd_act_q;
        wr_act_d = wr_act_q;
        eop_d    = eop_q;
        if (DACK && !IOR_N && !IOW_N) begin
          // Conflicting strobes: abandon any strobe in progress
          err_set_c = 1'b1;
          rd_act_d  = 1'b0;
          wr_act_d  = 1'b0;
          eop_d     = 1'b0;
        end else if (rd_act_q && IOR_N) begin
          dma_pop_c = 1'b1;
          rd_act_d  = 1'b0;
          eop_d     = 1'b0;
          state_d   = (eop_q || !EOP_N) ? DONE : (xfer_more_c ? XFER : IDLE);
        end else if (wr_act_q && IOW_N) begin
          dma_push_c = 1'b1;
          wr_act_d   = 1'b0;
          eop_d      = 1'b0;
          state_d    = (eop_q || !EOP_N) ? DONE : (xfer_more_c ? XFER : IDLE);
        end else if (DACK && !IOR_N) begin
          if ((dir_q == DIR_DEV2MEM) && !fifo_empty) begin
            rd_act_d = 1'b1;
            if (!EOP_N) eop_d = 1'b1;
          end else begin
            err_set_c = 1'b1;  // wrong direction or read of an empty FIFO
          end
        end else if (DACK && !IOW_N) begin
          if (dir_q == DIR_MEM2DEV) begin
            wr_act_d = 1'b1;
            wdata_d  = DB_in;  // last low cycle wins
            if (!EOP_N) eop_d = 1'b1;
          end else begin
            err_set_c = 1'b1;
          end
        end else if (!DACK) begin
          state_d = IDLE;
        end
      end

      DONE: begin
        if (tcClear) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      dir_q       <= DIR_DEV2MEM;
      rd_act_q    <= 1'b0;
      wr_act_q    <= 1'b0;
      eop_q       <= 1'b0;
      wdata_q     <= '0;
      dreq_q      <= 1'b0;
      tc_seen_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      rd_act_q    <= rd_act_d;
      wr_act_q    <= wr_act_d;
      eop_q       <= eop_d;
      wdata_q     <= wdata_d;
      dreq_q      <= (state_d == REQ) || (state_d == XFER);
      tc_seen_q   <= (state_d == DONE) || (tc_seen_q && !tcClear);
      proto_err_q <= proto_err_q || err_set_c;
    end
  end

  assign DREQ       = dreq_q;
  assign tcSeen     = tc_seen_q;
  assign protoErr   = proto_err_q;
  assign fifoCount  = fifo_count;
  assign DB_oe      = rd_strobe_c;
  assign DB_out     = (rd_strobe_c && !fifo_empty) ? fifo_head : '0;
  assign devWrReady = !RESET && !fifo_full && (dir_q == DIR_DEV2MEM);
  assign devRdValid = !fifo_empty && (dir_q == DIR_MEM2DEV);
  assign devRdData  = devRdValid ? fifo_head : '0;

endmodule

// File: tb/tb_dma_io_endpoint.sv
// Self-checking bench for dma_io_endpoint: directed handshake steps with
// random data, checked against a queue model of the FIFO and sticky flags.
module tb_dma_io_endpoint;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FIFO_DEPTH = 8;
`ifdef DMA_DEMAND_MODE_EN
  localparam logic DEMAND = 1'b1;
`else
  localparam logic DEMAND = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RESET;
  logic              dir;
  logic              enable;
  logic              DREQ;
  logic              DACK;
  logic              IOR_N;
  logic              IOW_N;
  logic              EOP_N;
  logic [DATA_W-1:0] DB_in;
  logic [DATA_W-1:0] DB_out;
  logic              DB_oe;
  logic [DATA_W-1:0] devWrData;
  logic              devWrValid;
  logic              devWrReady;
  logic [DATA_W-1:0] devRdData;
  logic              devRdValid;
  logic              devRdReady;
  logic [3:0]        fifoCount;
  logic              tcSeen;
  logic              tcClear;
  logic              protoErr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] q[$];   // model FIFO contents
  logic              m_err;  // model sticky protocol error

  dma_io_endpoint #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .dir        (dir),
    .enable     (enable),
    .DREQ       (DREQ),
    .DACK       (DACK),
    .IOR_N      (IOR_N),
    .IOW_N      (IOW_N),
    .EOP_N      (EOP_N),
    .DB_in      (DB_in),
    .DB_out     (DB_out),
    .DB_oe      (DB_oe),
    .devWrData  (devWrData),
    .devWrValid (devWrValid),
    .devWrReady (devWrReady),
    .devRdData  (devRdData),
    .devRdValid (devRdValid),
    .devRdReady (devRdReady),
    .fifoCount  (fifoCount),
    .tcSeen     (tcSeen),
    .tcClear    (tcClear),
    .protoErr   (protoErr)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_dreq(input string tag);
    int n;
    n = 0;
    while (DREQ !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(DREQ), 32'd1);
  endtask

  task automatic local_push(input logic [DATA_W-1:0] d);
    devWrValid = 1'b1;
    devWrData  = d;
    tick();
    devWrValid = 1'b0;
    if (q.size() < FIFO_DEPTH) q.push_back(d);
  endtask

  // One DMA read strobe; optional local push in the completion cycle
  task automatic dma_read(input bit eop, input int low_cycles, input bit lpush,
                          input logic [DATA_W-1:0] ldata);
    logic [DATA_W-1:0] exp_head;
    bit                was_full;
    exp_head = q[0];
    IOR_N = 1'b0;
    EOP_N = !eop;
    #1;
    check("rd_oe", 32'(DB_oe), 32'd1);
    check("rd_data", 32'(DB_out), 32'(exp_head));
    for (int i = 0; i < low_cycles; i++) tick();
    check("rd_data_hold", 32'(DB_out), 32'(exp_head));
    IOR_N      = 1'b1;
    devWrValid = lpush;
    devWrData  = ldata;
    #1;
    check("rd_oe_off", 32'(DB_oe), 32'd0);
    was_full = (q.size() == FIFO_DEPTH);
    tick();
    EOP_N      = 1'b1;
    devWrValid = 1'b0;
    void'(q.pop_front());
    if (lpush && !was_full) q.push_back(ldata);
    check("rd_count", 32'(fifoCount), 32'(q.size()));
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    bool_init();
    // Reset state
    RESET = 1'b1;
    tick();
    tick();
    check("rst_dreq", 32'(DREQ), 32'd0);
    check("rst_oe", 32'(DB_oe), 32'd0);
    check("rst_dbout", 32'(DB_out), 32'd0);
    check("rst_count", 32'(fifoCount), 32'd0);
    check("rst_tc", 32'(tcSeen), 32'd0);
    check("rst_err", 32'(protoErr), 32'd0);
    check("rst_wrrdy", 32'(devWrReady), 32'd0);
    check("rst_rdvld", 32'(devRdValid), 32'd0);
    RESET = 1'b0;
    tick();
    check("post_rst_wrrdy", 32'(devWrReady), 32'd1);

    // Device-to-memory: two pushes, DREQ two cycles after the first push
    enable = 1'b1;
    local_push(8'hA5);
    check("t1_dreq_early", 32'(DREQ), 32'd0);
    local_push(8'h3C);
    check("t1_dreq", 32'(DREQ), 32'd1);
    check("t1_count", 32'(fifoCount), 32'd2);
    DACK = 1'b1;
    tick();
    dma_read(1'b0, 2, 1'b0, '0);
    check("t1_dreq_after", 32'(DREQ), 32'(DEMAND));
    tick();
    check("t1_rereq", 32'(DREQ), 32'd1);
    tick();
    dma_read(1'b0, 1, 1'b0, '0);
    check("t1_dreq_empty", 32'(DREQ), 32'd0);
    tick();
    check("t1_idle_empty", 32'(DREQ), 32'd0);

    // Memory-to-device: one IOW_N strobe
    dir = 1'b1;
    tick();
    check("t2_dreq", 32'(DREQ), 32'd1);
    tick();
    d     = 8'($urandom);
    DB_in = d;
    IOW_N = 1'b0;
    tick();
    IOW_N = 1'b1;
    DB_in = 8'($urandom);
    tick();
    q.push_back(d);
    check("t2_count", 32'(fifoCount), 32'(q.size()));
    check("t2_rdvld", 32'(devRdValid), 32'd1);
    check("t2_rddata", 32'(devRdData), 32'(d));
    check("t2_dreq_after", 32'(DREQ), 32'(DEMAND));
    enable = 1'b0;
    DACK   = 1'b0;
    tick();
    check("t2_dreq_idle", 32'(DREQ), 32'd0);
    devRdReady = 1'b1;
    tick();
    devRdReady = 1'b0;
    void'(q.pop_front());
    check("t2_pop_count", 32'(fifoCount), 32'(q.size()));
    check("t2_rdvld_off", 32'(devRdValid), 32'd0);

    // Random pushes and single DMA reads, some with a simultaneous local push
    dir = 1'b0;
    tick();
    for (int it = 0; it < 6; it++) begin
      int k;
      k = $urandom_range(1, 3);
      for (int j = 0; j < k; j++) local_push(8'($urandom));
      check("rnd_count", 32'(fifoCount), 32'(q.size()));
      enable = 1'b1;
      wait_dreq("rnd_dreq");
      DACK = 1'b1;
      tick();
      dma_read(1'b0, $urandom_range(1, 3), 1'($urandom_range(0, 1)), 8'($urandom));
      enable = 1'b0;
      DACK   = 1'b0;
      tick();
    end

    // Full FIFO, read with EOP -> DONE until tcClear
    while (q.size() < FIFO_DEPTH) local_push(8'($urandom));
    local_push(8'($urandom));
    check("t3_full_count", 32'(fifoCount), 32'd8);
    check("t3_wrrdy_full", 32'(devWrReady), 32'd0);
    enable = 1'b1;
    wait_dreq("t3_dreq");
    DACK = 1'b1;
    tick();
    dma_read(1'b1, 1, 1'b0, '0);
    check("t3_done_dreq", 32'(DREQ), 32'd0);
    check("t3_tc", 32'(tcSeen), 32'd1);
    tick();
    tick();
    check("t3_done_hold", 32'(DREQ), 32'd0);
    check("t3_tc_hold", 32'(tcSeen), 32'd1);
    tcClear = 1'b1;
    tick();
    tcClear = 1'b0;
    check("t3_tc_clr", 32'(tcSeen), 32'd0);
    check("t3_idle_dreq", 32'(DREQ), 32'd0);
    tick();
    check("t3_rereq", 32'(DREQ), 32'd1);

    // Both strobes low in XFER: no transfer, protocol error
    tick();
    IOR_N = 1'b0;
    IOW_N = 1'b0;
    tick();
    IOR_N = 1'b1;
    IOW_N = 1'b1;
    tick();
    m_err = 1'b1;
    check("t4_err", 32'(protoErr), 32'(m_err));
    check("t4_count", 32'(fifoCount), 32'(q.size()));
    DACK = 1'b0;
    tick();
    check("t4_dack_drop", 32'(DREQ), 32'd0);
    check("t4_count_keep", 32'(fifoCount), 32'(q.size()));

    // Full FIFO: blocked local push alongside a DMA pop
    enable = 1'b0;
    tick();
    tick();
    while (q.size() < FIFO_DEPTH) local_push(8'($urandom));
    check("t5_wrrdy_full", 32'(devWrReady), 32'd0);
    enable = 1'b1;
    wait_dreq("t5_dreq");
    DACK = 1'b1;
    tick();
    dma_read(1'b0, 1, 1'b1, 8'($urandom));
    check("t5_count7", 32'(fifoCount), 32'd7);
    check("t5_wrrdy", 32'(devWrReady), 32'd1);

    // Reset in the middle of an IOR_N strobe
    wait_dreq("t5_dreq2");
    tick();
    IOR_N = 1'b0;
    tick();
    check("t5_oe_mid", 32'(DB_oe), 32'd1);
    RESET = 1'b1;
    tick();
    q.delete();
    m_err = 1'b0;
    check("t5_rst_dreq", 32'(DREQ), 32'd0);
    check("t5_rst_oe", 32'(DB_oe), 32'd0);
    check("t5_rst_count", 32'(fifoCount), 32'(q.size()));
    check("t5_rst_err", 32'(protoErr), 32'(m_err));
    RESET  = 1'b0;
    IOR_N  = 1'b1;
    enable = 1'b0;
    DACK   = 1'b0;
    tick();

`ifdef DMA_DEMAND_MODE_EN
    // Demand mode: DREQ held across back-to-back strobes until empty
    for (int j = 0; j < 3; j++) local_push(8'($urandom));
    enable = 1'b1;
    wait_dreq("dm_dreq");
    DACK = 1'b1;
    tick();
    for (int j = 0; j < 3; j++) begin
      dma_read(1'b0, 1, 1'b0, '0);
      check("dm_dreq_hold", 32'(DREQ), (j < 2) ? 32'd1 : 32'd0);
    end
    DACK   = 1'b0;
    enable = 1'b0;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic bool_init();
    RESET      = 1'b1;
    dir        = 1'b0;
    enable     = 1'b0;
    DACK       = 1'b0;
    IOR_N      = 1'b1;
    IOW_N      = 1'b1;
    EOP_N      = 1'b1;
    DB_in      = '0;
    devWrData  = '0;
    devWrValid = 1'b0;
    devRdReady = 1'b0;
    tcClear    = 1'b0;
    m_err      = 1'b0;
  endtask

endmodule
